pc_unit: RTL and testbench



---
 rtl/pc_unit_pkg.sv | 20 ++
 rtl/pc_unit_if.sv | 30 +++
 rtl/pc_unit_btb_dm.sv | 61 ++++++
 rtl/pc_unit.sv | 81 ++++++++
 tb/tb_pc_unit.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/pc_unit_pkg.sv
// Shared definitions for the fetch-side program-counter unit: next-PC op
// encodings, reset vector default and the taken-control-flow predicate.
package pc_unit_pkg;

    localparam int unsigned XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_ADD4     = 2'b00,
        PC_ADD_IMM  = 2'b01,
        PC_IMM_JALR = 2'b10,
        PC_RSVD     = 2'b11   // behaves as PC_ADD4
    } pc_op_e;

    // True when the resolved instruction redirects control flow away from pc+4.
    function automatic logic is_taken_cf(input logic [1:0] op, input logic taken);
        return ((pc_op_e'(op) == PC_ADD_IMM) && taken) || (pc_op_e'(op) == PC_IMM_JALR);
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Fetch/execute bus of the PC unit. The slave side is the PC unit itself;
// the master side is the surrounding pipeline (fetch back-pressure and execute).
interface pc_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            stall_i;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pred_npc_o;
    logic            ex_valid_i;
    logic [XLEN-1:0] ex_pc_i;
    logic [XLEN-1:0] ex_pred_npc_i;
    logic [1:0]      ex_op_i;
    logic            ex_taken_i;
    logic [XLEN-1:0] ex_rs1_i;
    logic [XLEN-1:0] ex_imm_i;
    logic            flush_o;
    logic [XLEN-1:0] redirect_pc_o;

    modport slave (
        input  stall_i, ex_valid_i, ex_pc_i, ex_pred_npc_i, ex_op_i, ex_taken_i,
               ex_rs1_i, ex_imm_i,
        output pc_o, pred_npc_o, flush_o, redirect_pc_o
    );

    modport master (
        output stall_i, ex_valid_i, ex_pc_i, ex_pred_npc_i, ex_op_i, ex_taken_i,
               ex_rs1_i, ex_imm_i,
        input  pc_o, pred_npc_o, flush_o, redirect_pc_o
    );
endinterface

// File: rtl/pc_unit_btb_dm.sv
// Direct-mapped branch target buffer: combinational lookup port and one
// synchronous write / invalidate port. Only the valid bits are reset.
module btb_dm #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            hit,
    output logic [XLEN-1:0] hit_target,
    input  logic            wr_en,
    input  logic            inv_en,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] wr_target
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic             upd_match;
    logic             unused_bits;

    assign lk_idx  = lookup_pc[IDX_W+1:2];
    assign lk_tag  = lookup_pc[XLEN-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[XLEN-1:IDX_W+2];

    // Instruction-alignment bits never take part in index or tag.
    assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    // Lookup reads pre-edge contents; no write-to-read bypass.
    assign hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign hit_target = target_q[lk_idx];
    assign upd_match  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Valid bits: set on taken update, cleared only when the resident tag matches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[upd_idx] <= 1'b1;
        end else if (inv_en && upd_match) begin
            valid_q[upd_idx] <= 1'b0;
        end
    end

    // Tag/target payload; an aliasing write simply overwrites the entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with BTB-based next-PC prediction and execute-stage
// mispredict detection / redirect.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned     XLEN        = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_PC_DEFAULT),
    parameter int unsigned     BTB_ENTRIES = 8,
    parameter bit              BTB_EN      = 1'b1
) (
    input logic       clk,
    input logic       rst_n,
    pc_unit_if.slave  bus
);
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pred_npc;
    logic [XLEN-1:0] actual;
    logic [XLEN-1:0] jalr_sum;
    logic            flush;
    logic            taken_cf;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign jalr_sum = bus.ex_rs1_i + bus.ex_imm_i;
    assign taken_cf = is_taken_cf(bus.ex_op_i, bus.ex_taken_i);

    // Resolve the architecturally correct next PC of the execute-stage instruction.
    always_comb begin
        actual = bus.ex_pc_i + XLEN'(4);
        case (pc_op_e'(bus.ex_op_i))
            PC_ADD_IMM: if (bus.ex_taken_i) actual = bus.ex_pc_i + bus.ex_imm_i;
            PC_IMM_JALR: actual = {jalr_sum[XLEN-1:1], 1'b0};
            default: ;
        endcase
    end

    assign flush = bus.ex_valid_i && (actual != bus.ex_pred_npc_i);

    generate
        if (BTB_EN) begin : g_btb
            logic            btb_hit;
            logic [XLEN-1:0] btb_target;

            btb_dm #(
                .XLEN    (XLEN),
                .ENTRIES (BTB_ENTRIES)
            ) u_btb (
                .clk        (clk),
                .rst_n      (rst_n),
                .lookup_pc  (pc_q),
                .hit        (btb_hit),
                .hit_target (btb_target),
                .wr_en      (bus.ex_valid_i && taken_cf),
                .inv_en     (bus.ex_valid_i && !taken_cf),
                .upd_pc     (bus.ex_pc_i),
                .wr_target  (actual)
            );

            assign pred_npc = btb_hit ? btb_target : pc_plus4;
        end else begin : g_no_btb
            assign pred_npc = pc_plus4;
        end
    endgenerate

    // Fetch PC: a redirect beats back-pressure, otherwise follow the prediction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (flush) begin
            pc_q <= actual;
        end else if (!bus.stall_i) begin
            pc_q <= pred_npc;
        end
    end

    assign bus.pc_o          = pc_q;
    assign bus.pred_npc_o    = pred_npc;
    assign bus.flush_o       = flush;
    assign bus.redirect_pc_o = actual;

endmodule

// File: tb/tb_pc_unit.sv
// Directed, table-driven bench for pc_unit: sequential fetch, stall, BTB
// training/invalidation, JALR redirect under stall, aliasing and mid-run reset.
module tb_pc_unit;
    import pc_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pc_unit_if #(.XLEN(32)) bus ();

    pc_unit #(
        .XLEN        (32),
        .RESET_PC    (32'h0),
        .BTB_ENTRIES (8),
        .BTB_EN      (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        stall;
        logic        ex_valid;
        logic [1:0]  op;
        logic        taken;
        logic [31:0] ex_pc;
        logic [31:0] ex_pred;
        logic [31:0] rs1;
        logic [31:0] imm;
        logic [31:0] exp_pc;
        logic [31:0] exp_pred;
        logic        exp_flush;
        logic [31:0] exp_redirect;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic stall, input logic ex_valid, input logic [1:0] op,
                         input logic taken, input logic [31:0] ex_pc, input logic [31:0] pred,
                         input logic [31:0] rs1, input logic [31:0] imm);
        bus.stall_i       = stall;
        bus.ex_valid_i    = ex_valid;
        bus.ex_op_i       = op;
        bus.ex_taken_i    = taken;
        bus.ex_pc_i       = ex_pc;
        bus.ex_pred_npc_i = pred;
        bus.ex_rs1_i      = rs1;
        bus.ex_imm_i      = imm;
    endtask

    initial begin
        // stall, ex_valid, op, taken, ex_pc, ex_pred, rs1, imm, exp_pc, exp_pred, flush, redirect
        vecs[0]  = '{0, 0, PC_ADD4, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 0, 32'h0};
        vecs[1]  = '{0, 0, PC_ADD4, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h8, 0, 32'h0};
        vecs[2]  = '{1, 0, PC_ADD4, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8, 32'hC, 0, 32'h0};
        vecs[3]  = '{1, 0, PC_ADD4, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8, 32'hC, 0, 32'h0};
        vecs[4]  = '{1, 0, PC_ADD4, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8, 32'hC, 0, 32'h0};
        vecs[5]  = '{0, 0, PC_ADD4, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8, 32'hC, 0, 32'h0};
        // cold taken branch at 0x10 -> 0x30
        vecs[6]  = '{0, 1, PC_ADD_IMM, 1, 32'h10, 32'h14, 32'h0, 32'h20, 32'hC, 32'h10, 1, 32'h30};
        vecs[7]  = '{0, 0, PC_ADD4, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h30, 32'h34, 0, 32'h0};
        // branch back to 0x10 from 0x40
        vecs[8]  = '{0, 1, PC_ADD_IMM, 1, 32'h40, 32'h44, 32'h0, 32'hFFFF_FFD0,
                     32'h34, 32'h38, 1, 32'h10};
        // trained hit, correctly predicted re-resolve
        vecs[9]  = '{0, 1, PC_ADD_IMM, 1, 32'h10, 32'h30, 32'h0, 32'h20, 32'h10, 32'h30, 0, 32'h30};
        // trained entry resolves not taken -> invalidate
        vecs[10] = '{0, 1, PC_ADD_IMM, 0, 32'h10, 32'h30, 32'h0, 32'h20, 32'h30, 32'h34, 1, 32'h14};
        vecs[11] = '{0, 1, PC_ADD_IMM, 1, 32'h40, 32'h44, 32'h0, 32'hFFFF_FFD0,
                     32'h14, 32'h18, 1, 32'h10};
        vecs[12] = '{0, 0, PC_ADD4, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h10, 32'h14, 0, 32'h0};
        // JALR with stall asserted: flush still loads the target
        vecs[13] = '{1, 1, PC_IMM_JALR, 0, 32'h200, 32'h1008, 32'h1003, 32'h4,
                     32'h14, 32'h18, 1, 32'h1006};
        vecs[14] = '{1, 0, PC_ADD4, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1006, 32'h100A, 0, 32'h0};
        vecs[15] = '{0, 0, PC_ADD4, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1006, 32'h100A, 0, 32'h0};
        // aliasing: 0x10 then 0x30 share index 4
        vecs[16] = '{0, 1, PC_ADD_IMM, 1, 32'h10, 32'h14, 32'h0, 32'h20,
                     32'h100A, 32'h100E, 1, 32'h30};
        vecs[17] = '{0, 1, PC_ADD_IMM, 1, 32'h30, 32'h34, 32'h0, 32'h100,
                     32'h30, 32'h34, 1, 32'h130};
        vecs[18] = '{0, 1, PC_ADD_IMM, 1, 32'h40, 32'h44, 32'h0, 32'hFFFF_FFD0,
                     32'h130, 32'h134, 1, 32'h10};
        vecs[19] = '{0, 1, PC_IMM_JALR, 0, 32'h300, 32'h304, 32'h30, 32'h0,
                     32'h10, 32'h14, 1, 32'h30};
        // reserved op behaves as ADD4 even with taken=1
        vecs[20] = '{0, 1, PC_RSVD, 1, 32'h500, 32'h504, 32'h0, 32'h40,
                     32'h30, 32'h130, 0, 32'h504};
        vecs[21] = '{0, 0, PC_ADD4, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h130, 32'h134, 0, 32'h0};

        rst_n = 1'b0;
        drive(0, 0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset pc", bus.pc_o, 32'h0);
        check("reset pred", bus.pred_npc_o, 32'h4);
        check("reset flush", {31'b0, bus.flush_o}, 32'h0);
        #2 rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].stall, vecs[i].ex_valid, vecs[i].op, vecs[i].taken, vecs[i].ex_pc,
                  vecs[i].ex_pred, vecs[i].rs1, vecs[i].imm);
            #1;
            check($sformatf("v%0d pc", i), bus.pc_o, vecs[i].exp_pc);
            check($sformatf("v%0d pred", i), bus.pred_npc_o, vecs[i].exp_pred);
            check($sformatf("v%0d flush", i), {31'b0, bus.flush_o}, {31'b0, vecs[i].exp_flush});
            if (vecs[i].ex_valid)
                check($sformatf("v%0d redirect", i), bus.redirect_pc_o, vecs[i].exp_redirect);
            @(posedge clk);
            #1;
        end

        // Mid-run asynchronous reset: pc returns at once, BTB contents are lost.
        drive(0, 0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        check("midrst pc", bus.pc_o, 32'h0);
        check("midrst pred", bus.pred_npc_o, 32'h4);
        check("midrst flush", {31'b0, bus.flush_o}, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("postrst pc", bus.pc_o, 32'h0);
        drive(0, 1, PC_IMM_JALR, 0, 32'h300, 32'h304, 32'h30, 32'h0);
        #1;
        check("postrst flush", {31'b0, bus.flush_o}, 32'h1);
        check("postrst redirect", bus.redirect_pc_o, 32'h30);
        @(posedge clk);
        #1;
        drive(0, 0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        check("postrst pc30", bus.pc_o, 32'h30);
        check("postrst pred30", bus.pred_npc_o, 32'h34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
